// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and helpers for the 7-segment scan driver.
//   HEX_SEG_TBL  : 16-entry nibble -> {g,f,e,d,c,b,a} table, active-high
//   SEG_OFF      : all segments dark, active-high
//   seg7_decode(): table lookup wrapper
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    return HEX_SEG_TBL[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational hex nibble to 7-segment decode (active-high).
//   nib_i : hex nibble
//   seg_o : segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_decode(nib_i);

endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: time-multiplexed 7-segment display driver with per-digit
// blanking, blinking and decimal points.
//   Fg_CLK      : system clock
//   Ext_RESET   : asynchronous reset, active-high
//   iDigits     : hex nibbles, digit0 = [3:0] (rightmost)
//   iDp         : decimal point per digit, 1 = lit
//   iBlank      : 1 = digit permanently dark
//   iBlinkMask  : 1 = digit blinks
//   iLoad       : strobe, captures the four inputs above into shadow regs
//   oSeg / oDp  : segments {g,f,e,d,c,b,a} and decimal point, polarity per SEG_ACT_LOW
//   oDigSel     : one-hot digit enable, polarity per DIG_ACT_LOW
//   oFrameDone  : 1-cycle pulse as the last digit slot ends
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 24000,
  parameter int unsigned GUARD        = 240,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic                    Fg_CLK,
  input  logic                    Ext_RESET,
  input  logic [4*NUM_DIGITS-1:0] iDigits,
  input  logic [NUM_DIGITS-1:0]   iDp,
  input  logic [NUM_DIGITS-1:0]   iBlank,
  input  logic [NUM_DIGITS-1:0]   iBlinkMask,
  input  logic                    iLoad,
  output logic [6:0]              oSeg,
  output logic                    oDp,
  output logic [NUM_DIGITS-1:0]   oDigSel,
  output logic                    oFrameDone
);

  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PreW-1:0]       PreLast  = PreW'(SCAN_DIV - 1);
  localparam logic [PreW-1:0]       PreGuard = PreW'(GUARD);
  localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrmW-1:0]       FrmLast  = FrmW'(BLINK_FRAMES - 1);
  localparam logic [6:0]            SegInact = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigInact = {NUM_DIGITS{DIG_ACT_LOW}};

  // Scan state
  logic [PreW-1:0] pre_q, pre_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [FrmW-1:0] frm_q, frm_d;
  logic            phase_q, phase_d;  // 1 = blinking digits lit

  // Shadow registers, written only by iLoad
  logic [NUM_DIGITS-1:0][3:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]      sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]      sh_blink_q, sh_blink_d;

  // Per-slot copy of the current digit; frozen for the whole slot
  logic [3:0] slot_nib_q, slot_nib_d;
  logic       slot_dp_q, slot_dp_d;
  logic       slot_blank_q, slot_blank_d;
  logic       slot_blink_q, slot_blink_d;

  // Output registers
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_act;
  logic                  dp_act;
  logic [NUM_DIGITS-1:0] dig_act;

  seg7_hex_dec u_hex_dec (
    .nib_i (slot_nib_q),
    .seg_o (dec_seg)
  );

  assign slot_end  = (pre_q == PreLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  // Counters and blink phase
  always_comb begin
    pre_d   = pre_q + 1'b1;
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    if (slot_end) begin
      pre_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frm_q == FrmLast) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Shadow and slot capture. The slot samples the shadow as it stands before
  // this edge, so an iLoad coinciding with slot start shows up one slot later.
  always_comb begin
    sh_dig_d   = iLoad ? iDigits    : sh_dig_q;
    sh_dp_d    = iLoad ? iDp        : sh_dp_q;
    sh_blank_d = iLoad ? iBlank     : sh_blank_q;
    sh_blink_d = iLoad ? iBlinkMask : sh_blink_q;

    slot_nib_d   = slot_nib_q;
    slot_dp_d    = slot_dp_q;
    slot_blank_d = slot_blank_q;
    slot_blink_d = slot_blink_q;
    if (pre_q == '0) begin
      slot_nib_d   = sh_dig_q[idx_q];
      slot_dp_d    = sh_dp_q[idx_q];
      slot_blank_d = sh_blank_q[idx_q];
      slot_blink_d = sh_blink_q[idx_q];
    end
  end

  // Output decode in active-high terms, then map to pin polarity. The guard
  // window at slot start keeps every digit off so the previous digit's
  // segments cannot ghost onto the next one.
  always_comb begin
    dig_act = '0;
    seg_act = SEG_OFF;
    dp_act  = 1'b0;
    if (pre_q >= PreGuard) begin
      dig_act[idx_q] = 1'b1;
      if (!(slot_blank_q || (slot_blink_q && !phase_q))) begin
        seg_act = dec_seg;
        dp_act  = slot_dp_q;
      end
    end
    seg_d = seg_act ^ SegInact;
    dp_d  = dp_act ^ SEG_ACT_LOW;
    dig_d = dig_act ^ DigInact;
  end

  always_ff @(posedge Fg_CLK or posedge Ext_RESET) begin
    if (Ext_RESET) begin
      pre_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b1;
      sh_dig_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_blink_q   <= '0;
      slot_nib_q   <= '0;
      slot_dp_q    <= 1'b0;
      slot_blank_q <= 1'b0;
      slot_blink_q <= 1'b0;
      seg_q        <= SegInact;
      dp_q         <= SEG_ACT_LOW;
      dig_q        <= DigInact;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      sh_dig_q     <= sh_dig_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_blink_q   <= sh_blink_d;
      slot_nib_q   <= slot_nib_d;
      slot_dp_q    <= slot_dp_d;
      slot_blank_q <= slot_blank_d;
      slot_blink_q <= slot_blink_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
    end
  end

  assign oSeg       = seg_q;
  assign oDp        = dp_q;
  assign oDigSel    = dig_q;
  assign oFrameDone = frame_end;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: self-checking bench for seg7_scan_drv. A reference model
// advanced once per clock pushes the expected outputs onto a queue; each
// scenario task pops and compares, and adds directed checks of its own.
module tb_seg7_scan_drv;

  localparam int unsigned NumDigits   = 4;
  localparam int unsigned ScanDiv     = 8;
  localparam int unsigned Guard       = 2;
  localparam int unsigned BlinkFrames = 2;

  logic        Fg_CLK    = 1'b0;
  logic        Ext_RESET = 1'b0;
  logic [15:0] iDigits   = '0;
  logic [3:0]  iDp       = '0;
  logic [3:0]  iBlank    = '0;
  logic [3:0]  iBlinkMask = '0;
  logic        iLoad     = 1'b0;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [3:0]  oDigSel;
  logic        oFrameDone;

  seg7_scan_drv #(
    .NUM_DIGITS   (NumDigits),
    .SCAN_DIV     (ScanDiv),
    .GUARD        (Guard),
    .BLINK_FRAMES (BlinkFrames),
    .SEG_ACT_LOW  (1'b1),
    .DIG_ACT_LOW  (1'b1)
  ) dut (
    .Fg_CLK     (Fg_CLK),
    .Ext_RESET  (Ext_RESET),
    .iDigits    (iDigits),
    .iDp        (iDp),
    .iBlank     (iBlank),
    .iBlinkMask (iBlinkMask),
    .iLoad      (iLoad),
    .oSeg       (oSeg),
    .oDp        (oDp),
    .oDigSel    (oDigSel),
    .oFrameDone (oFrameDone)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] obs_w;
  int          checks = 0;
  int          errors = 0;

  assign obs_w = {oDigSel, oSeg, oDp, oFrameDone};

  // Reference model state
  int          m_pre, m_idx, m_frame;
  logic        m_phase;
  logic [15:0] m_sh_dig;
  logic [3:0]  m_sh_dp, m_sh_blank, m_sh_blink;
  logic [3:0]  m_slot_nib;
  logic        m_slot_dp, m_slot_blank, m_slot_blink;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_frame = 0; m_phase = 1'b1;
    m_sh_dig = '0; m_sh_dp = '0; m_sh_blank = '0; m_sh_blink = '0;
    m_slot_nib = '0; m_slot_dp = 1'b0; m_slot_blank = 1'b0; m_slot_blink = 1'b0;
  endtask

  // Advance one clock: expected outputs come from the pre-edge model state,
  // oFrameDone from the post-edge state. Returns at the following negedge.
  task automatic tick();
    exp_t e;
    if (Ext_RESET) begin
      model_reset();
      e = '{dig: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    end else begin
      e = '{dig: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      if (m_pre >= Guard) begin
        e.dig = ~(4'b0001 << m_idx);
        if (!(m_slot_blank || (m_slot_blink && !m_phase))) begin
          e.seg = ~hex_seg(m_slot_nib);
          e.dp  = ~m_slot_dp;
        end
      end
      if (m_pre == 0) begin
        m_slot_nib   = m_sh_dig[m_idx*4 +: 4];
        m_slot_dp    = m_sh_dp[m_idx];
        m_slot_blank = m_sh_blank[m_idx];
        m_slot_blink = m_sh_blink[m_idx];
      end
      if (iLoad) begin
        m_sh_dig = iDigits; m_sh_dp = iDp; m_sh_blank = iBlank; m_sh_blink = iBlinkMask;
      end
      if (m_pre == ScanDiv - 1) begin
        m_pre = 0;
        if (m_idx == NumDigits - 1) begin
          m_idx = 0;
          if (m_frame == BlinkFrames - 1) begin
            m_frame = 0;
            m_phase = ~m_phase;
          end else begin
            m_frame++;
          end
        end else begin
          m_idx++;
        end
      end else begin
        m_pre++;
      end
      e.fd = (m_pre == ScanDiv - 1) && (m_idx == NumDigits - 1);
    end
    @(posedge Fg_CLK);
    exp_q.push_back(e);
    @(negedge Fg_CLK);
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] blank, input logic [3:0] blink);
    iDigits = d; iDp = dp; iBlank = blank; iBlinkMask = blink; iLoad = 1'b1;
  endtask

  // At most one digit enabled at any sampled instant
  always @(negedge Fg_CLK) begin
    checks++;
    if (!$onehot0(~oDigSel)) begin
      errors++;
      $display("FAIL onehot t=%0t oDigSel=%b required at most one low bit", $time, oDigSel);
    end
  end

  task automatic test_reset();
    exp_t e;
    bit   seen;
    Ext_RESET = 1'b1;
    model_reset();
    repeat (2) @(negedge Fg_CLK);
    checks++;
    if (obs_w !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle got %b required %b", obs_w, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    Ext_RESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL reset_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
    end
    // Mid-slot (digit1 lit): asynchronous reset must blank at once
    #2 Ext_RESET = 1'b1;
    #1;
    checks++;
    if ({oDigSel, oSeg, oDp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got %b %h %b required 1111 7f 1", oDigSel, oSeg, oDp);
    end
    @(negedge Fg_CLK);
    model_reset();
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_w !== e) begin
      errors++;
      $display("FAIL reset_hold got %b required %b", obs_w, e);
    end
    Ext_RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL restart_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (!seen && oDigSel !== 4'hF) begin
        seen = 1'b1;
        checks++;
        if (oDigSel !== 4'b1110) begin
          errors++;
          $display("FAIL first_digit got %b required 1110", oDigSel);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_digit_seen got none required 1110 within 8 cycles");
    end
  endtask

  task automatic test_load();
    exp_t e;
    drive_load(16'h12AF, 4'b0010, 4'b0000, 4'b0000);
    for (int i = 0; i < 64; i++) begin
      tick();
      iLoad = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL load_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (i >= 32) begin
        if (oDigSel == 4'b1110) begin
          checks++;
          if ({oSeg, oDp} !== {7'h0E, 1'b1}) begin
            errors++;
            $display("FAIL digit0_F got %h/%b required 0e/1", oSeg, oDp);
          end
        end else if (oDigSel == 4'b1101) begin
          checks++;
          if ({oSeg, oDp} !== {7'h08, 1'b0}) begin
            errors++;
            $display("FAIL digit1_A_dp got %h/%b required 08/0", oSeg, oDp);
          end
        end else if (oDigSel == 4'b0111) begin
          checks++;
          if (oSeg !== 7'h79) begin
            errors++;
            $display("FAIL digit3_1 got %h required 79", oSeg);
          end
        end else if (oDigSel == 4'hF) begin
          checks++;
          if ({oSeg, oDp} !== {7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL guard_off got %h/%b required 7f/1", oSeg, oDp);
          end
        end
      end
    end
  endtask

  task automatic test_scan();
    exp_t       e;
    int         last_fd;
    logic [3:0] prev;
    last_fd = -1;
    prev    = 4'hF;
    for (int i = 0; i < 72; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (oFrameDone) begin
        if (last_fd >= 0) begin
          checks++;
          if (i - last_fd != 32) begin
            errors++;
            $display("FAIL frame_period got %0d required 32", i - last_fd);
          end
        end
        last_fd = i;
      end
      if (oDigSel !== 4'hF && oDigSel !== prev) begin
        if (prev !== 4'hF) begin
          checks++;
          if (oDigSel !== {prev[2:0], prev[3]}) begin
            errors++;
            $display("FAIL digit_order got %b required %b", oDigSel, {prev[2:0], prev[3]});
          end
        end
        prev = oDigSel;
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int   fr;
    int   dark3;
    int   lit[6];
    Ext_RESET = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_w !== e) begin
      errors++;
      $display("FAIL blink_reset got %b required %b", obs_w, e);
    end
    Ext_RESET = 1'b0;
    drive_load(16'h12AF, 4'b0000, 4'b0000, 4'b0001);
    fr = 0;
    dark3 = 0;
    for (int f = 0; f < 6; f++) lit[f] = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      iLoad = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL blink_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (fr < 6 && oDigSel == 4'b1110 && oSeg !== 7'h7F) lit[fr]++;
      if (oDigSel == 4'b0111 && oSeg === 7'h7F) dark3++;
      if (oFrameDone) fr++;
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if ((f == 2 || f == 3) ? (lit[f] != 0) : (lit[f] == 0)) begin
        errors++;
        $display("FAIL blink_frame%0d digit0 lit cycles %0d required %s", f, lit[f],
                 (f == 2 || f == 3) ? "0" : "nonzero");
      end
    end
    checks++;
    if (dark3 != 0) begin
      errors++;
      $display("FAIL blink_digit3 dark cycles %0d required 0", dark3);
    end
  endtask

  task automatic test_midslot();
    exp_t e;
    bit   found;
    bit   left;
    drive_load(16'h0800, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      tick();
      iLoad = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL mid_prep cyc=%0d got %b required %b", i, obs_w, e);
      end
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL mid_wait cyc=%0d got %b required %b", i, obs_w, e);
      end
      found = (oDigSel == 4'b1011);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_find got none required oDigSel 1011 within 40 cycles");
    end
    drive_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
    left = 1'b0;
    for (int i = 0; i < 40 && !left; i++) begin
      tick();
      iLoad = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL mid_hold_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (oDigSel == 4'b1011) begin
        checks++;
        if (oSeg !== 7'h00) begin
          errors++;
          $display("FAIL mid_hold got %h required 00", oSeg);
        end
      end
      left = (oDigSel == 4'hF);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL mid_next_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (oDigSel == 4'b1011) begin
        found = 1'b1;
        checks++;
        if (oSeg !== 7'h40) begin
          errors++;
          $display("FAIL mid_next got %h required 40", oSeg);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_next_seen got none required oDigSel 1011 within 40 cycles");
    end
  endtask

  task automatic test_blank();
    exp_t e;
    int   active;
    drive_load(16'h8888, 4'b1111, 4'b1111, 4'b0000);
    active = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      iLoad = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (obs_w !== e) begin
        errors++;
        $display("FAIL blank_scan cyc=%0d got %b required %b", i, obs_w, e);
      end
      if (i >= 8) begin
        checks++;
        if ({oSeg, oDp} !== {7'h7F, 1'b1}) begin
          errors++;
          $display("FAIL blank_seg cyc=%0d got %h/%b required 7f/1", i, oSeg, oDp);
        end
        if (oDigSel !== 4'hF) active++;
      end
    end
    checks++;
    if (active == 0) begin
      errors++;
      $display("FAIL blank_digsel got 0 active cycles required nonzero");
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_scan();
    test_blink();
    test_midslot();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
